alu_operand_loader: RTL and testbench

//  Operand-entry stage directly upstream of the 4-bit ALU. Captures A, B and the 3-bit opcode

---
 rtl/alu_operand_loader_pkg.sv | 24 ++
 rtl/alu_operand_loader_btn_debounce.sv | 52 +++++
 rtl/alu_operand_loader.sv | 111 +++++++++++
 tb/tb_alu_operand_loader.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/alu_operand_loader_pkg.sv
// Shared definitions for the ALU operand-entry stage: step states, ALU opcodes, default widths.
package alu_operand_loader_pkg;

  localparam int W_DEF   = 4;
  localparam int OPW_DEF = 3;

  // Encoding is visible on the board LEDs, so the values are fixed.
  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_OP   = 2'd2,
    S_SHOW = 2'd3
  } step_state_t;

  localparam logic [OPW_DEF-1:0] OP_ADD = 3'd0;
  localparam logic [OPW_DEF-1:0] OP_SUB = 3'd1;
  localparam logic [OPW_DEF-1:0] OP_NOT = 3'd2;
  localparam logic [OPW_DEF-1:0] OP_AND = 3'd3;
  localparam logic [OPW_DEF-1:0] OP_OR  = 3'd4;
  localparam logic [OPW_DEF-1:0] OP_XOR = 3'd5;
  localparam logic [OPW_DEF-1:0] OP_CMP = 3'd6;
  localparam logic [OPW_DEF-1:0] OP_EQ  = 3'd7;

endpackage

// File: rtl/alu_operand_loader_btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter, one-cycle pulse on accepted press.
module btn_debounce #(
  parameter int DEB_CYC = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = $clog2(DEB_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYC - 1);

  logic             s1_q, s2_q;
  logic             level_q, level_d;
  logic             prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A level change is accepted only after DEB_CYC consecutive disagreeing samples.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (s2_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= raw;
      s2_q    <= s1_q;
      level_q <= level_d;
      prev_q  <= level_q;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = level_q & ~prev_q;

endmodule

// File: rtl/alu_operand_loader.sv
// Operand-entry stage: each debounced button press captures A, then B, then the opcode.
module alu_operand_loader
  import alu_operand_loader_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int OPW     = OPW_DEF,
  parameter int DEB_CYC = 1000000
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [W-1:0]   sw,
  input  logic [OPW-1:0] op_sw,
  input  logic           btn,
  output logic [W-1:0]   a,
  output logic [W-1:0]   b,
  output logic [OPW-1:0] op,
  output logic           opnd_valid,
  output logic [1:0]     step_state
);

  logic           step;
  logic           btn_level;
  logic [W-1:0]   sw_s1_q, sw_s2_q;
  logic [OPW-1:0] op_sw_s1_q, op_sw_s2_q;

  step_state_t    state_q, state_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic [OPW-1:0] op_q, op_d;
  logic           valid_q, valid_d;

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn),
    .level (btn_level),
    .rise  (step)
  );

  // Switches are quasi-static; the synchronizers only guard against metastability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      op_sw_s1_q <= '0;
      op_sw_s2_q <= '0;
    end else begin
      sw_s1_q    <= sw;
      sw_s2_q    <= sw_s1_q;
      op_sw_s1_q <= op_sw;
      op_sw_s2_q <= op_sw_s1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    valid_d = valid_q;
    if (step) begin
      case (state_q)
        S_A: begin
          a_d     = sw_s2_q;
          valid_d = 1'b0;
          state_d = S_B;
        end
        S_B: begin
          b_d     = sw_s2_q;
          state_d = S_OP;
        end
        S_OP: begin
          op_d    = op_sw_s2_q;
          valid_d = 1'b1;
          state_d = S_SHOW;
        end
        S_SHOW: begin
          valid_d = 1'b0;
          state_d = S_A;
        end
        default: state_d = S_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      valid_q <= valid_d;
    end
  end

  assign a          = a_q;
  assign b          = b_q;
  assign op         = op_q;
  assign opnd_valid = valid_q;
  assign step_state = state_q;

  // The settled button level has no consumer here; only the press pulse is used.
  logic unused_level;
  assign unused_level = btn_level;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader with a short debounce window.
module tb_alu_operand_loader;

  localparam int W       = 4;
  localparam int OPW     = 3;
  localparam int DEB_CYC = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [W-1:0]   sw;
  logic [OPW-1:0] op_sw;
  logic           btn;
  logic [W-1:0]   a, b;
  logic [OPW-1:0] op;
  logic           opnd_valid;
  logic [1:0]     step_state;

  int n_cmp = 0;
  int n_err = 0;
  int n_chg = 0;
  logic [1:0] last_state = 2'd0;

  alu_operand_loader #(.W(W), .OPW(OPW), .DEB_CYC(DEB_CYC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw         (sw),
    .op_sw      (op_sw),
    .btn        (btn),
    .a          (a),
    .b          (b),
    .op         (op),
    .opnd_valid (opnd_valid),
    .step_state (step_state)
  );

  always #5 clk = ~clk;

  // Counts every observed step_state change, to catch repeated or missing steps.
  always @(negedge clk) begin
    if (step_state !== last_state) n_chg++;
    last_state <= step_state;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [W-1:0] sw_v, input logic [OPW-1:0] op_v);
    sw    = sw_v;
    op_sw = op_v;
    btn   = 1'b1;
    cycles(10);
    btn   = 1'b0;
    cycles(10);
    @(negedge clk);
  endtask

  task automatic check_outs(input string tag, input logic [3:0] ea, input logic [3:0] eb,
                            input logic [2:0] eop, input logic ev, input logic [1:0] es);
    check({tag, ".a"},     32'(a),          32'(ea));
    check({tag, ".b"},     32'(b),          32'(eb));
    check({tag, ".op"},    32'(op),         32'(eop));
    check({tag, ".valid"}, 32'(opnd_valid), 32'(ev));
    check({tag, ".state"}, 32'(step_state), 32'(es));
  endtask

  initial begin
    int chg0;
    rst_n = 1'b0;
    btn   = 1'b1;
    sw    = 4'hF;
    op_sw = 3'd7;
    cycles(5);
    @(negedge clk);
    check_outs("reset", 4'h0, 4'h0, 3'd0, 1'b0, 2'd0);

    // Button held through reset release: one press, no repeat while held.
    rst_n = 1'b1;
    cycles(25);
    btn = 1'b0;
    cycles(10);
    @(negedge clk);
    check_outs("held_at_reset", 4'hF, 4'h0, 3'd0, 1'b0, 2'd1);

    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(2);
    @(negedge clk);
    check("rereset.state", 32'(step_state), 32'd0);

    // Full load: 3 + 5 with ADD.
    press(4'h3, 3'd7);
    check_outs("load_a", 4'h3, 4'h0, 3'd0, 1'b0, 2'd1);
    press(4'h5, 3'd7);
    check_outs("load_b", 4'h3, 4'h5, 3'd0, 1'b0, 2'd2);
    press(4'h9, 3'd0);
    check_outs("load_op", 4'h3, 4'h5, 3'd0, 1'b1, 2'd3);
    check("alu_sum", 32'(a) + 32'(b), 32'd8);

    // Short glitch: 3 cycles high is below the debounce window.
    chg0 = n_chg;
    btn = 1'b1;
    cycles(3);
    btn = 1'b0;
    cycles(15);
    @(negedge clk);
    check("glitch.changes", 32'(n_chg - chg0), 32'd0);
    check_outs("glitch", 4'h3, 4'h5, 3'd0, 1'b1, 2'd3);

    // Wrap from S_SHOW back to S_A keeps the old operands.
    press(4'hC, 3'd6);
    check_outs("wrap", 4'h3, 4'h5, 3'd0, 1'b0, 2'd0);
    press(4'hA, 3'd6);
    check_outs("wrap_a", 4'hA, 4'h5, 3'd0, 1'b0, 2'd1);

    // Bounce: 10 alternating 2-cycle segments, then a clean hold.
    sw = 4'h7;
    chg0 = n_chg;
    for (int i = 0; i < 10; i++) begin
      btn = (i % 2 == 0);
      cycles(2);
    end
    btn = 1'b1;
    cycles(6);
    @(negedge clk);
    check("bounce.early", 32'(step_state), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("bounce.on_time", 32'(step_state), 32'd2);
    cycles(10);
    btn = 1'b0;
    cycles(10);
    @(negedge clk);
    check("bounce.changes", 32'(n_chg - chg0), 32'd1);
    check_outs("bounce", 4'hA, 4'h7, 3'd0, 1'b0, 2'd2);

    press(4'h0, 3'd5);
    check_outs("op_xor", 4'hA, 4'h7, 3'd5, 1'b1, 2'd3);
    press(4'h0, 3'd0);
    press(4'h1, 3'd0);
    press(4'h2, 3'd0);
    check_outs("pre_midreset", 4'h1, 4'h2, 3'd5, 1'b0, 2'd2);

    // Asynchronous reset in S_OP, sampled before any clock edge.
    rst_n = 1'b0;
    #1;
    check_outs("midreset", 4'h0, 4'h0, 3'd0, 1'b0, 2'd0);
    cycles(2);
    rst_n = 1'b1;
    cycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
